// File: rtl/ram_copy_pkg.sv
// Shared types and request classification for the RAM block-copy engine.
// The classifier decides copy direction so that no source word is read after it is overwritten.
package ram_copy_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} copy_state_t;

  typedef enum logic {ASC, DESC} copy_dir_t;

  typedef struct packed {
    copy_dir_t dir;
    logic      err;
  } copy_class_t;

  // d is the forward distance from source to destination, taken modulo the RAM size n.
  function automatic copy_class_t classify(input int unsigned src, input int unsigned dst,
                                           input int unsigned len, input int unsigned n);
    int unsigned d;
    copy_class_t c;
    d     = (dst - src) & (n - 1);
    c.dir = ASC;
    c.err = 1'b0;
    if (len > n) begin
      c.err = 1'b1;
    end else if (len != 0) begin
      if (d != 0 && d < len && (n - d) < len) begin
        c.err = 1'b1;
      end else if (d >= 1 && d <= len - 1) begin
        c.dir = DESC;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ram_copy_addr_gen.sv
// Loadable wrapping up/down address counter with a word budget; tc flags the final step.
module ram_copy_addr_gen
  import ram_copy_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  copy_dir_t             load_dir,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  tc
);

  logic [ADDR_WIDTH:0] count;
  copy_dir_t           dir;

  assign tc = step && (count == (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
      dir   <= ASC;
    end else if (load) begin
      addr  <= load_addr;
      count <= load_count;
      dir   <= load_dir;
    end else if (step && count != '0) begin
      addr  <= (dir == DESC) ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
      count <= count - (ADDR_WIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/ram_copy_engine.sv
// memmove-style block copy inside a dual-port RAM: port A reads, port B writes, one word per cycle.
// The write side trails the read side by exactly the RAM's one-cycle read latency.
module ram_copy_engine
  import ram_copy_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b
);

  localparam int unsigned N = 1 << ADDR_WIDTH;

  copy_state_t           state, next_state;
  copy_class_t           cls;
  logic                  accept, load, empty_req;
  logic                  reading, rd_valid_q, err_q;
  logic                  rd_tc, wr_tc, write_now;
  logic [ADDR_WIDTH-1:0] len_lo, rd_start, wr_start;

  assign cls       = classify(32'(src_addr), 32'(dst_addr), 32'(length), N);
  assign empty_req = (length == '0);
  assign accept    = (state == IDLE) && start;
  assign load      = accept && !empty_req && !cls.err;
  assign len_lo    = length[ADDR_WIDTH-1:0];

  // Descending copies begin at the last word of each region.
  assign rd_start = (cls.dir == DESC) ? src_addr + len_lo - ADDR_WIDTH'(1) : src_addr;
  assign wr_start = (cls.dir == DESC) ? dst_addr + len_lo - ADDR_WIDTH'(1) : dst_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = load ? RUN : DONE;
      RUN:     if (wr_tc) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN);
    done       = (state == DONE);
    err        = (state == DONE) && err_q;
    write_now  = (state == RUN) && rd_valid_q;
    ram_we_b   = write_now;
    ram_din_b  = write_now ? ram_dout_a : '0;
    ram_we_a   = 1'b0;
    ram_din_a  = '0;
  end

  // rd_valid_q marks that last cycle's read data is now on ram_dout_a.
  always_ff @(posedge clk) begin
    if (rst) begin
      reading    <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= reading;
      if (accept) err_q <= cls.err;
      if (load)       reading <= 1'b1;
      else if (rd_tc) reading <= 1'b0;
    end
  end

  ram_copy_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_addr  (rd_start),
    .load_count (length),
    .load_dir   (cls.dir),
    .step       (reading),
    .addr       (ram_addr_a),
    .tc         (rd_tc)
  );

  ram_copy_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_addr  (wr_start),
    .load_count (length),
    .load_dir   (cls.dir),
    .step       (write_now),
    .addr       (ram_addr_b),
    .tc         (wr_tc)
  );

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench: behavioural RAM plus a memmove reference model of the expected copy.
module tb_ram_copy_engine;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   length;
  logic          busy, done, err;
  logic          ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a;

  logic [DW-1:0] mem [N];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int src;
    int dst;
    int len;
    int exp_err;
    int exp_done;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  ram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_dout_a (ram_dout_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_din_b  (ram_din_b)
  );

  // Dual-port RAM with registered port-A read; the bench preload shares port B.
  always @(posedge clk) begin
    if (pre_we)        mem[pre_addr] <= pre_data;
    else if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    ram_dout_a <= mem[ram_addr_a];
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic preload(input bit rand_fill);
    for (int i = 0; i < N; i++) begin
      pre_we   = 1'b1;
      pre_addr = AW'(i);
      pre_data = rand_fill ? DW'($urandom) : DW'(8'h10 + i);
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
  endtask

  function automatic int ref_err(input int src, input int dst, input int len);
    int d;
    d = ((dst - src) % N + N) % N;
    if (len == 0) return 0;
    if (len > N) return 1;
    if (d != 0 && d < len && (N - d) < len) return 1;
    return 0;
  endfunction

  // Called right after a rising edge in IDLE; that cycle is cycle 0.
  task automatic apply_stimulus(input int src, input int dst, input int len,
                                input int exp_err, input int exp_done);
    logic [DW-1:0] snap [N];
    logic [DW-1:0] exp_mem [N];
    int  ra [N];
    int  wa [N];
    int  d;
    bit  valid, desc, exp_we;
    for (int i = 0; i < N; i++) snap[i] = mem[i];
    exp_mem = snap;
    d     = ((dst - src) % N + N) % N;
    valid = (exp_err == 0) && (len != 0);
    desc  = (d >= 1) && (d <= len - 1);
    if (valid) begin
      for (int i = 0; i < len; i++) exp_mem[(dst + i) % N] = snap[(src + i) % N];
      for (int i = 0; i < len; i++) begin
        ra[i] = desc ? (src + len - 1 - i) % N : (src + i) % N;
        wa[i] = desc ? (dst + len - 1 - i) % N : (dst + i) % N;
      end
    end

    start    = 1'b1;
    src_addr = AW'(src);
    dst_addr = AW'(dst);
    length   = (AW+1)'(len);
    @(posedge clk); #1;
    for (int k = 1; k <= exp_done + 1; k++) begin
      if (k < exp_done) begin
        start    = 1'($urandom_range(0, 1));
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        length   = (AW+1)'($urandom_range(0, 31));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      exp_we = valid && k >= 2 && k <= len + 1;
      check_output("busy", int'(busy), int'(valid && k <= len + 1));
      check_output("done", int'(done), int'(k == exp_done));
      if (k == exp_done) check_output("err", int'(err), exp_err);
      check_output("we_b", int'(ram_we_b), int'(exp_we));
      if (valid && k <= len) check_output("rd_addr", int'(ram_addr_a), ra[k-1]);
      if (exp_we) begin
        check_output("wr_addr", int'(ram_addr_b), wa[k-2]);
        check_output("wr_data", int'(ram_din_b), int'(exp_mem[wa[k-2]]));
      end else begin
        check_output("din_b_idle", int'(ram_din_b), 0);
      end
      if (k == 1) begin
        check_output("we_a", int'(ram_we_a), 0);
        check_output("din_a", int'(ram_din_a), 0);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) check_output("mem_word", int'(mem[i]), int'(exp_mem[i]));
  endtask

  initial begin
    int s, t, l;

    vecs[0] = '{src: 2,  dst: 8, len: 4,  exp_err: 0, exp_done: 6};
    vecs[1] = '{src: 0,  dst: 2, len: 5,  exp_err: 0, exp_done: 7};
    vecs[2] = '{src: 4,  dst: 2, len: 5,  exp_err: 0, exp_done: 7};
    vecs[3] = '{src: 14, dst: 3, len: 4,  exp_err: 0, exp_done: 6};
    vecs[4] = '{src: 0,  dst: 1, len: 16, exp_err: 1, exp_done: 1};
    vecs[5] = '{src: 5,  dst: 5, len: 0,  exp_err: 0, exp_done: 1};
    vecs[6] = '{src: 3,  dst: 7, len: 17, exp_err: 1, exp_done: 1};

    rst      = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_err", int'(err), 0);
    check_output("rst_we_b", int'(ram_we_b), 0);
    check_output("rst_addr_a", int'(ram_addr_a), 0);
    check_output("rst_addr_b", int'(ram_addr_b), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      preload(1'b0);
      apply_stimulus(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].exp_err, vecs[v].exp_done);
    end

    // Reset in cycle 3 of an 8-word copy: two words land, then writing stops with no done.
    preload(1'b0);
    start    = 1'b1;
    src_addr = 4'd0;
    dst_addr = 4'd8;
    length   = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_mid_we_c3", int'(ram_we_b), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      @(negedge clk);
      check_output("rst_mid_we", int'(ram_we_b), 0);
      check_output("rst_mid_done", int'(done), 0);
      check_output("rst_mid_busy", int'(busy), 0);
      @(posedge clk); #1;
    end
    check_output("rst_mid_mem8", int'(mem[8]), 8'h10);
    check_output("rst_mid_mem9", int'(mem[9]), 8'h11);
    check_output("rst_mid_mem10", int'(mem[10]), 8'h1A);
    preload(1'b0);
    apply_stimulus(2, 8, 4, 0, 6);

    for (int r = 0; r < 40; r++) begin
      preload(1'b1);
      s = $urandom_range(0, N - 1);
      t = $urandom_range(0, N - 1);
      l = $urandom_range(0, N + 1);
      apply_stimulus(s, t, l, ref_err(s, t, l), (ref_err(s, t, l) == 0 && l != 0) ? l + 2 : 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
